// File: rtl/rc522_txn_ctrl_if.sv
// ----------------------------------------------------------------------------
// rc522_txn_ctrl_if
// Bundles every signal of the MFRC522 transaction sequencer except clk/rst:
// the request channel from the tag-reader FSMs, the write-data and read-data
// byte streams, the done/error pulses, and the byte-wide SPI engine link with
// chip-select.
//   slave  : the sequencer's view (it serves requests and drives the engine)
//   master : the environment's view (requester plus SPI shift engine)
// ----------------------------------------------------------------------------
interface rc522_txn_ctrl_if #(
    parameter int LENW = 5
);
    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [5:0]      req_addr;
    logic [LENW-1:0] req_len;
    logic [7:0]      wr_data;
    logic            wr_valid;
    logic            wr_ready;
    logic [7:0]      rd_data;
    logic            rd_valid;
    logic            txn_done;
    logic            txn_err;
    logic            spi_start;
    logic [7:0]      spi_tx;
    logic [7:0]      spi_rx;
    logic            spi_done;
    logic            spi_cs_n;

    modport slave (
        input  req_valid, req_write, req_addr, req_len,
        input  wr_data, wr_valid,
        input  spi_rx, spi_done,
        output req_ready, wr_ready,
        output rd_data, rd_valid,
        output txn_done, txn_err,
        output spi_start, spi_tx, spi_cs_n
    );

    modport master (
        output req_valid, req_write, req_addr, req_len,
        output wr_data, wr_valid,
        output spi_rx, spi_done,
        input  req_ready, wr_ready,
        input  rd_data, rd_valid,
        input  txn_done, txn_err,
        input  spi_start, spi_tx, spi_cs_n
    );
endinterface

// File: rtl/rc522_txn_ctrl.sv
// ----------------------------------------------------------------------------
// rc522_txn_ctrl
// Transaction sequencer for the MFRC522 SPI link. Accepts one register-level
// request (single or burst, read or write), emits the address byte followed by
// the data bytes to a byte-wide SPI shift engine, and keeps chip-select low
// for the whole transaction.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous reset, active-high
//   bus  - rc522_txn_ctrl_if.slave: request channel (req_*), write stream
//          (wr_*), read stream (rd_*), txn_done/txn_err pulses, SPI engine
//          link (spi_start/spi_tx/spi_rx/spi_done) and spi_cs_n
// ----------------------------------------------------------------------------
module rc522_txn_ctrl #(
    parameter int MAX_BURST = 16,
    parameter int LENW      = 5,
    parameter int CS_SETUP  = 2,
    parameter int CS_HOLD   = 2,
    parameter int TIMEOUT   = 1024
) (
    input logic              clk,
    input logic              rst,
    rc522_txn_ctrl_if.slave  bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_ADDR   = 3'd2;
    localparam logic [2:0] S_WRDATA = 3'd3;
    localparam logic [2:0] S_XFER   = 3'd4;
    localparam logic [2:0] S_HOLD   = 3'd5;

    localparam int PHASE_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int CNTW      = $clog2(PHASE_MAX + 1);
    localparam int TMOW      = $clog2(TIMEOUT + 1);

    logic [2:0]      state;
    logic [7:0]      addr_byte;
    logic            is_write;
    logic [LENW-1:0] remaining;
    logic [CNTW-1:0] phase_cnt;
    logic [TMOW-1:0] tmo_cnt;
    logic            err_pending;
    logic            cs_n;
    logic            spi_start;
    logic [7:0]      spi_tx;
    logic [7:0]      rd_data;
    logic            rd_valid;
    logic            txn_done;
    logic            txn_err;
    logic [LENW-1:0] len_clamped;
    logic            tmo_hit;

    // A zero length still moves one byte; anything longer than a FIFO burst
    // is cut down to MAX_BURST so the down-counter never wraps.
    always_comb begin
        len_clamped = bus.req_len;
        if (bus.req_len == '0) begin
            len_clamped = LENW'(1);
        end else if (bus.req_len > LENW'(MAX_BURST)) begin
            len_clamped = LENW'(MAX_BURST);
        end
    end

    assign tmo_hit = (tmo_cnt == TMOW'(TIMEOUT - 1));

    assign bus.req_ready = (state == S_IDLE);
    assign bus.wr_ready  = (state == S_WRDATA);
    assign bus.spi_cs_n  = cs_n;
    assign bus.spi_start = spi_start;
    assign bus.spi_tx    = spi_tx;
    assign bus.rd_data   = rd_data;
    assign bus.rd_valid  = rd_valid;
    assign bus.txn_done  = txn_done;
    assign bus.txn_err   = txn_err;

    // Sequencer. 'remaining' counts data bytes not yet finished by the
    // engine; in a read burst the last byte shifts out 8'h00 so the chip
    // does not start yet another FIFO read. The timeout counter only runs
    // while waiting on the engine, so a slow write-data source never aborts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            addr_byte   <= '0;
            is_write    <= 1'b0;
            remaining   <= '0;
            phase_cnt   <= '0;
            tmo_cnt     <= '0;
            err_pending <= 1'b0;
            cs_n        <= 1'b1;
            spi_start   <= 1'b0;
            spi_tx      <= '0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            txn_done    <= 1'b0;
            txn_err     <= 1'b0;
        end else begin
            spi_start <= 1'b0;
            rd_valid  <= 1'b0;
            txn_done  <= 1'b0;
            txn_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        is_write    <= bus.req_write;
                        addr_byte   <= {~bus.req_write, bus.req_addr, 1'b0};
                        remaining   <= len_clamped;
                        phase_cnt   <= '0;
                        err_pending <= 1'b0;
                        cs_n        <= 1'b0;
                        state       <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (phase_cnt == CNTW'(CS_SETUP - 1)) begin
                        spi_start <= 1'b1;
                        spi_tx    <= addr_byte;
                        tmo_cnt   <= '0;
                        state     <= S_ADDR;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                S_ADDR: begin
                    if (bus.spi_done) begin
                        if (is_write) begin
                            state <= S_WRDATA;
                        end else begin
                            spi_start <= 1'b1;
                            spi_tx    <= (remaining == LENW'(1)) ? 8'h00 : addr_byte;
                            tmo_cnt   <= '0;
                            state     <= S_XFER;
                        end
                    end else if (tmo_hit) begin
                        err_pending <= 1'b1;
                        phase_cnt   <= '0;
                        state       <= S_HOLD;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_WRDATA: begin
                    if (bus.wr_valid) begin
                        spi_tx    <= bus.wr_data;
                        spi_start <= 1'b1;
                        tmo_cnt   <= '0;
                        state     <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (bus.spi_done) begin
                        remaining <= remaining - 1'b1;
                        if (!is_write) begin
                            rd_data  <= bus.spi_rx;
                            rd_valid <= 1'b1;
                        end
                        if (remaining == LENW'(1)) begin
                            phase_cnt <= '0;
                            state     <= S_HOLD;
                        end else if (is_write) begin
                            state <= S_WRDATA;
                        end else begin
                            spi_start <= 1'b1;
                            spi_tx    <= (remaining == LENW'(2)) ? 8'h00 : addr_byte;
                            tmo_cnt   <= '0;
                        end
                    end else if (tmo_hit) begin
                        err_pending <= 1'b1;
                        phase_cnt   <= '0;
                        state       <= S_HOLD;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (phase_cnt == CNTW'(CS_HOLD - 1)) begin
                        cs_n <= 1'b1;
                        if (err_pending) begin
                            txn_err <= 1'b1;
                        end else begin
                            txn_done <= 1'b1;
                        end
                        state <= S_IDLE;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                default: begin
                    cs_n  <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rc522_txn_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rc522_txn_ctrl
// Self-checking bench for rc522_txn_ctrl. A behavioural SPI engine answers
// spi_start after a programmable delay (or never, to force a timeout) and
// records every byte shifted out. Expected byte streams are built from the
// transaction rules: address byte {~write, addr, 0}, then either the written
// data or, for reads, the address byte repeated with 8'h00 as the last byte.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rc522_txn_ctrl;

    localparam int MAX_BURST = 16;
    localparam int LENW      = 5;
    localparam int CS_SETUP  = 2;
    localparam int CS_HOLD   = 2;
    localparam int TIMEOUT   = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rc522_txn_ctrl_if #(.LENW(LENW)) bus ();

    rc522_txn_ctrl #(
        .MAX_BURST(MAX_BURST),
        .LENW     (LENW),
        .CS_SETUP (CS_SETUP),
        .CS_HOLD  (CS_HOLD),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         write;
        logic [5:0] addr;
        logic [4:0] len;
        int         gap;
        int         delay;
        int         wr_byte;
        int         rd_byte;
        int         exp_addr_byte;
        int         exp_data;
        int         exp_tx1;
        int         exp_rd0;
    } vec_t;

    vec_t vecs[8];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int  eng_delay = 0;
    int  eng_wait  = 0;
    int  eng_limit = -1;
    bit  eng_busy  = 0;
    logic [7:0] rx_byte;
    logic [7:0] rx_preload[$];
    logic [7:0] tx_q[$];
    logic [7:0] eng_rx_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] wr_sent[$];
    logic [7:0] exp_tx[$];

    int done_cnt, err_cnt, cs_viol, overlap, rd_timing;
    int first_start_cyc, last_start_cyc, last_done_cyc, cs_fall_cyc, end_cyc;
    bit in_txn = 0;
    bit accept_pending = 0;

    bit         cur_write;
    logic [5:0] cur_addr;
    logic [4:0] cur_len;

    function automatic int numBytes(input logic [4:0] l);
        if (l == 0) return 1;
        if (int'(l) > MAX_BURST) return MAX_BURST;
        return int'(l);
    endfunction

    task automatic checkEq(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: bound expired, got no event expected one", name);
    endtask

    // Monitor and SPI engine share one process so their view of each
    // negative edge is ordered: the monitor looks first, then the engine reacts.
    initial begin
        bus.spi_done = 1'b0;
        bus.spi_rx   = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                in_txn         = 0;
                accept_pending = 0;
                eng_busy       = 0;
                bus.spi_done   = 1'b0;
            end else begin
                if (accept_pending) begin
                    in_txn      = 1;
                    cs_fall_cyc = cyc;
                end
                accept_pending = bus.req_valid && bus.req_ready;
                if (bus.txn_done || bus.txn_err) begin
                    if (bus.txn_done) done_cnt++;
                    if (bus.txn_err) err_cnt++;
                    if (!bus.spi_cs_n) cs_viol++;
                    end_cyc = cyc;
                    in_txn  = 0;
                end else if (in_txn && bus.spi_cs_n) begin
                    cs_viol++;
                end
                if (bus.rd_valid) begin
                    rd_q.push_back(bus.rd_data);
                    if (cyc != last_done_cyc + 1) rd_timing++;
                end
                bus.spi_done = 1'b0;
                if (bus.spi_start) begin
                    if (eng_busy) overlap++;
                    if (bus.spi_cs_n) cs_viol++;
                    tx_q.push_back(bus.spi_tx);
                    if (first_start_cyc < 0) first_start_cyc = cyc;
                    last_start_cyc = cyc;
                    eng_busy = 1;
                    eng_wait = eng_delay;
                end else if (eng_busy && eng_limit != 0) begin
                    if (eng_wait > 0) begin
                        eng_wait--;
                    end else begin
                        if (rx_preload.size() > 0) rx_byte = rx_preload.pop_front();
                        else rx_byte = 8'($urandom);
                        bus.spi_rx    = rx_byte;
                        bus.spi_done  = 1'b1;
                        eng_rx_q.push_back(rx_byte);
                        eng_busy      = 0;
                        last_done_cyc = cyc;
                        if (eng_limit > 0) eng_limit--;
                    end
                end
            end
        end
    end

    task automatic clearStats();
        tx_q.delete();
        eng_rx_q.delete();
        rd_q.delete();
        wr_sent.delete();
        done_cnt = 0; err_cnt = 0; cs_viol = 0; overlap = 0; rd_timing = 0;
        first_start_cyc = -1; last_start_cyc = -1; last_done_cyc = -100;
        cs_fall_cyc = -1; end_cyc = -1;
    endtask

    task automatic issueRequest(input bit w, input logic [5:0] a, input logic [4:0] l);
        int waited;
        waited = 0;
        while (!bus.req_ready && waited < 100) begin
            @(posedge clk); #2;
            waited++;
        end
        if (!bus.req_ready) failNow("req_ready_wait");
        cur_write = w; cur_addr = a; cur_len = l;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_len   = l;
        @(posedge clk); #2;
        bus.req_valid = 1'b0;
        bus.req_write = 1'($urandom);
        bus.req_addr  = 6'($urandom);
        bus.req_len   = 5'($urandom);
    endtask

    task automatic applyStimulus(input bit w, input logic [5:0] a, input logic [4:0] l,
                                 input int gap, input int delay, input int fixed_wr);
        int n;
        int waited;
        clearStats();
        eng_delay = delay;
        issueRequest(w, a, l);
        if (w) begin
            n = numBytes(l);
            for (int i = 0; i < n; i++) begin
                repeat (gap) begin @(posedge clk); #2; end
                bus.wr_valid = 1'b1;
                bus.wr_data  = (fixed_wr >= 0) ? 8'(fixed_wr) : 8'($urandom);
                waited = 0;
                while (!bus.wr_ready && waited < 2000) begin
                    @(posedge clk); #2;
                    waited++;
                end
                if (!bus.wr_ready) begin
                    bus.wr_valid = 1'b0;
                    failNow("wr_handshake_wait");
                    break;
                end
                wr_sent.push_back(bus.wr_data);
                @(posedge clk); #2;
                bus.wr_valid = 1'b0;
            end
        end
        waited = 0;
        while (done_cnt + err_cnt == 0 && waited < TIMEOUT + 2000) begin
            @(posedge clk); #2;
            waited++;
        end
        if (done_cnt + err_cnt == 0) failNow("txn_end_wait");
        repeat (2) begin @(posedge clk); #2; end
    endtask

    // Expected engine byte stream built from the transaction rules alone.
    task automatic buildExpected();
        int n;
        logic [7:0] ab;
        n  = numBytes(cur_len);
        ab = {~cur_write, cur_addr, 1'b0};
        exp_tx.delete();
        exp_tx.push_back(ab);
        if (cur_write) begin
            foreach (wr_sent[i]) exp_tx.push_back(wr_sent[i]);
        end else begin
            for (int i = 0; i < n; i++) exp_tx.push_back((i == n - 1) ? 8'h00 : ab);
        end
    endtask

    task automatic checkOutput(input int exp_first, input int exp_data, input int exp_tx1, input int exp_rd0);
        int n;
        n = numBytes(cur_len);
        buildExpected();
        checkEq("done_pulses", done_cnt, 1);
        checkEq("err_pulses", err_cnt, 0);
        checkEq("tx_count", tx_q.size(), n + 1);
        for (int i = 0; i < exp_tx.size() && i < tx_q.size(); i++)
            checkEq($sformatf("tx_byte[%0d]", i), int'(tx_q[i]), int'(exp_tx[i]));
        if (cur_write) begin
            checkEq("wr_handshakes", wr_sent.size(), n);
            checkEq("rd_count_write", rd_q.size(), 0);
        end else begin
            checkEq("rd_count", rd_q.size(), n);
            for (int i = 0; i < rd_q.size() && i + 1 < eng_rx_q.size(); i++)
                checkEq($sformatf("rd_byte[%0d]", i), int'(rd_q[i]), int'(eng_rx_q[i + 1]));
        end
        checkEq("cs_violations", cs_viol, 0);
        checkEq("start_overlap", overlap, 0);
        checkEq("rd_valid_timing", rd_timing, 0);
        checkEq("cs_setup_cycles", first_start_cyc - cs_fall_cyc, CS_SETUP);
        checkEq("cs_hold_cycles", end_cyc - last_done_cyc, CS_HOLD + 1);
        checkEq("req_ready_after", int'(bus.req_ready), 1);
        checkEq("cs_n_after", int'(bus.spi_cs_n), 1);
        if (exp_first >= 0) begin
            if (tx_q.size() > 0) checkEq("table_addr_byte", int'(tx_q[0]), exp_first);
            else failNow("table_addr_byte");
        end
        if (exp_data >= 0) checkEq("table_data_bytes", tx_q.size() - 1, exp_data);
        if (exp_tx1 >= 0) begin
            if (tx_q.size() > 1) checkEq("table_tx1", int'(tx_q[1]), exp_tx1);
            else failNow("table_tx1");
        end
        if (exp_rd0 >= 0) begin
            if (rd_q.size() > 0) checkEq("table_rd0", int'(rd_q[0]), exp_rd0);
            else failNow("table_rd0");
        end
    endtask

    initial begin
        int waited;
        int lim;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;

        vecs[0] = '{1'b1, 6'h01, 5'd1,  0,  0, 8'h0F, -1, 8'h02, 1,  8'h0F, -1};
        vecs[1] = '{1'b0, 6'h37, 5'd1,  0,  1, -1, 8'h92, 8'hEE, 1,  8'h00, 8'h92};
        vecs[2] = '{1'b0, 6'h09, 5'd4,  0,  2, -1, -1,    8'h92, 4,  8'h92, -1};
        vecs[3] = '{1'b1, 6'h01, 5'd3,  20, 1, -1, -1,    8'h02, 3,  -1,    -1};
        vecs[4] = '{1'b0, 6'h3F, 5'd0,  0,  0, -1, -1,    8'hFE, 1,  8'h00, -1};
        vecs[5] = '{1'b1, 6'h12, 5'd20, 1,  0, -1, -1,    8'h24, 16, -1,    -1};
        vecs[6] = '{1'b0, 6'h00, 5'd16, 0,  3, -1, -1,    8'h80, 16, 8'h80, -1};
        vecs[7] = '{1'b1, 6'h3F, 5'd31, 0,  2, -1, -1,    8'h7E, 16, -1,    -1};

        clearStats();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checkEq("reset_cs_n", int'(bus.spi_cs_n), 1);
        checkEq("reset_req_ready", int'(bus.req_ready), 1);
        checkEq("reset_wr_ready", int'(bus.wr_ready), 0);
        checkEq("reset_pulses", int'({bus.spi_start, bus.rd_valid, bus.txn_done, bus.txn_err}), 0);
        checkEq("reset_spi_tx", int'(bus.spi_tx), 0);
        checkEq("reset_rd_data", int'(bus.rd_data), 0);
        rst = 1'b0;
        @(posedge clk); #2;

        $display("[TB] table-driven transactions");
        for (int v = 0; v < 8; v++) begin
            rx_preload.delete();
            if (vecs[v].rd_byte >= 0) begin
                rx_preload.push_back(8'hA5);
                rx_preload.push_back(8'(vecs[v].rd_byte));
            end
            applyStimulus(vecs[v].write, vecs[v].addr, vecs[v].len,
                          vecs[v].gap, vecs[v].delay, vecs[v].wr_byte);
            checkOutput(vecs[v].exp_addr_byte, vecs[v].exp_data, vecs[v].exp_tx1, vecs[v].exp_rd0);
        end
        rx_preload.delete();

        $display("[TB] engine timeout, stuck on address byte then mid-burst");
        for (int t = 0; t < 2; t++) begin
            lim = (t == 0) ? 0 : 2;
            eng_limit = lim;
            applyStimulus(1'b0, 6'h10, 5'd3, 0, 1, -1);
            checkEq("tmo_err_pulses", err_cnt, 1);
            checkEq("tmo_done_pulses", done_cnt, 0);
            checkEq("tmo_rd_count", rd_q.size(), (lim > 0) ? lim - 1 : 0);
            checkEq("tmo_start_count", tx_q.size(), lim + 1);
            checkEq("tmo_window_lo", int'(end_cyc - last_start_cyc >= TIMEOUT), 1);
            checkEq("tmo_window_hi", int'(end_cyc - last_start_cyc <= TIMEOUT + CS_HOLD + 2), 1);
            checkEq("tmo_cs_violations", cs_viol, 0);
            checkEq("tmo_cs_n_after", int'(bus.spi_cs_n), 1);
            checkEq("tmo_req_ready_after", int'(bus.req_ready), 1);
            eng_limit = -1;
            eng_busy  = 0;
            @(posedge clk); #2;
        end

        $display("[TB] reset during a read burst");
        clearStats();
        eng_delay = 3;
        issueRequest(1'b0, 6'h09, 5'd8);
        waited = 0;
        while (tx_q.size() < 3 && waited < 300) begin
            @(posedge clk); #2;
            waited++;
        end
        if (tx_q.size() < 3) failNow("burst_progress_wait");
        checkEq("cs_low_mid_txn", int'(bus.spi_cs_n), 0);
        checkEq("req_ready_busy", int'(bus.req_ready), 0);
        #1 rst = 1'b1;
        #1;
        checkEq("async_reset_cs_n", int'(bus.spi_cs_n), 1);
        checkEq("async_reset_ready", int'(bus.req_ready), 1);
        repeat (3) begin @(posedge clk); #2; end
        rst = 1'b0;
        repeat (5) begin @(posedge clk); #2; end
        checkEq("reset_no_end_pulse", done_cnt + err_cnt, 0);
        applyStimulus(1'b0, 6'h05, 5'd0, 0, 1, -1);
        checkOutput(8'h8A, 1, 8'h00, -1);

        $display("[TB] randomized transactions");
        for (int r = 0; r < 24; r++) begin
            applyStimulus(1'($urandom_range(0, 1)), 6'($urandom), 5'($urandom_range(0, 20)),
                          $urandom_range(0, 2), $urandom_range(0, 3), -1);
            checkOutput(-1, -1, -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
